// File: rtl/BwaMemDefines.sv
// Shared types for the MEM seeding scheduler: FSM state encoding,
// reseed candidate layout and default position / interval widths.
package BwaMemDefines;

  localparam int unsigned DEF_POS_W = 9;
  localparam int unsigned DEF_KLS_W = 40;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_SETTLE,
    S_CHK,
    S_RESEED,
    S_FLUSH,
    S_WFIL
  } SchedState;

  // Candidate as carried on rsc_tdata: i occupies the LSBs.
  typedef struct packed {
    logic [DEF_KLS_W-1:0] s;
    logic [DEF_POS_W-1:0] j;
    logic [DEF_POS_W-1:0] i;
  } ReseedCand;

endpackage

// File: rtl/mem_sched_fifo.sv
// First-word fall-through FIFO holding reseed candidates; a push into a
// full FIFO is accepted when a pop happens in the same cycle.
module mem_sched_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  output logic          ready_o,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic [AW:0]   count_o
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          full, empty, wr_en, rd_en;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign rd_en   = pop_i && !empty;
  assign ready_o = !full || rd_en;
  assign wr_en   = push_i && ready_o;
  assign dout_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + AW'(1);
      if (rd_en) rptr_q <= rptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/mem_seed_sched.sv
// Read-to-MEM scheduler: seeds across one read, queues reseed candidates,
// then runs the capped reseed pass. Optional stats via MEM_SEED_SCHED_STATS_EN.
module mem_seed_sched
  import BwaMemDefines::*;
#(
  parameter int unsigned MAX_READ_LEN = 250,
  parameter int unsigned POS_W        = DEF_POS_W,
  parameter int unsigned KLS_W        = DEF_KLS_W,
  parameter int unsigned RSQ_AW       = 5,
  parameter int unsigned MAX_RESEED   = 16,
  parameter int unsigned SETTLE_CYC   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [POS_W-1:0]         read_len,
  output logic                     finish,
  output logic                     busy,
  output logic                     sk_start,
  output logic [POS_W-1:0]         sk_pos,
  output logic [KLS_W-1:0]         sk_min_intv,
  output logic                     sk_min_intv_valid,
  input  logic                     sk_finish,
  input  logic [POS_W-1:0]         sk_nxt_pos,
  output logic                     rs_bypass,
  input  logic [2*POS_W+KLS_W-1:0] rsc_tdata,
  input  logic                     rsc_tvalid,
  output logic                     rsc_tready,
  output logic                     fil_start,
  output logic                     fil_stop,
  input  logic                     fil_finish,
  output logic                     rsq_overflow
`ifdef MEM_SEED_SCHED_STATS_EN
  ,
  output logic [15:0]              stat_seeks,
  output logic [7:0]               stat_reseeds,
  output logic [RSQ_AW:0]          stat_maxq
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_RESEED + 2);
  localparam int unsigned DW    = 2*POS_W + KLS_W;

  SchedState        state_q;
  logic [POS_W-1:0] glen_q, sk_pos_q;
  logic [KLS_W-1:0] min_intv_q;
  logic             sk_start_q, mv_q, fil_start_q, fil_stop_q, finish_q, ovf_q;
  logic [CNT_W-1:0] rcnt_q;
  logic [3:0]       settle_q;

  logic [DW-1:0]    q_dout;
  logic [RSQ_AW:0]  q_count;
  logic             q_empty, q_clr, pop_d, cap_ok, start_ok, seek_more;
  logic [POS_W-1:0] c_i, c_j;
  logic [KLS_W-1:0] c_s;
  logic [POS_W:0]   mid_sum;

  assign c_i     = q_dout[POS_W-1:0];
  assign c_j     = q_dout[2*POS_W-1:POS_W];
  assign c_s     = q_dout[DW-1:2*POS_W];
  assign mid_sum = {1'b0, c_i} + {1'b0, c_j} + (POS_W+1)'(1);

  assign q_empty   = (q_count == '0);
  assign cap_ok    = (rcnt_q < CNT_W'(MAX_RESEED));
  assign pop_d     = !q_empty && (((state_q == S_CHK) && cap_ok) || (state_q == S_FLUSH));
  assign q_clr     = (state_q == S_WFIL) && fil_finish;
  assign start_ok  = (state_q == S_IDLE) && start && (read_len <= POS_W'(MAX_READ_LEN));
  assign seek_more = (state_q == S_SEED) && sk_finish && (sk_nxt_pos < glen_q);

  mem_sched_fifo #(.DW(DW), .AW(RSQ_AW)) u_rsq (
    .clk     (clk),
    .rst_n   (reset_n),
    .clr_i   (q_clr),
    .push_i  (rsc_tvalid),
    .din_i   (rsc_tdata),
    .ready_o (rsc_tready),
    .pop_i   (pop_d),
    .dout_o  (q_dout),
    .count_o (q_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      glen_q      <= '0;
      sk_pos_q    <= '0;
      min_intv_q  <= '0;
      sk_start_q  <= 1'b0;
      mv_q        <= 1'b0;
      fil_start_q <= 1'b0;
      fil_stop_q  <= 1'b0;
      finish_q    <= 1'b0;
      ovf_q       <= 1'b0;
      rcnt_q      <= '0;
      settle_q    <= '0;
    end else begin
      sk_start_q  <= 1'b0;
      mv_q        <= 1'b0;
      fil_start_q <= 1'b0;
      fil_stop_q  <= 1'b0;
      finish_q    <= 1'b0;
      case (state_q)
        S_IDLE: if (start_ok) begin
          glen_q      <= read_len + POS_W'(2);
          sk_pos_q    <= POS_W'(1);
          min_intv_q  <= '0;
          fil_start_q <= 1'b1;
          ovf_q       <= 1'b0;
          rcnt_q      <= '0;
          settle_q    <= '0;
          if (read_len == '0) begin
            state_q <= S_SETTLE;
          end else begin
            state_q    <= S_SEED;
            sk_start_q <= 1'b1;
            mv_q       <= 1'b1;
          end
        end
        S_SEED: if (seek_more) begin
          sk_pos_q   <= sk_nxt_pos;
          sk_start_q <= 1'b1;
          mv_q       <= 1'b1;
        end else if (sk_finish) begin
          state_q  <= S_SETTLE;
          settle_q <= '0;
        end
        S_SETTLE: begin
          if (settle_q == 4'(SETTLE_CYC - 1)) state_q <= S_CHK;
          else                                settle_q <= settle_q + 4'd1;
        end
        S_CHK: begin
          if (q_empty) begin
            fil_stop_q <= 1'b1;
            state_q    <= S_WFIL;
          end else if (cap_ok) begin
            // Midpoint of the candidate span, rounded up, without overflow.
            sk_pos_q   <= mid_sum[POS_W:1];
            min_intv_q <= c_s;
            sk_start_q <= 1'b1;
            mv_q       <= 1'b1;
            rcnt_q     <= rcnt_q + CNT_W'(1);
            state_q    <= S_RESEED;
          end else begin
            state_q <= S_FLUSH;
          end
        end
        S_RESEED: if (sk_finish) state_q <= S_CHK;
        S_FLUSH: begin
          if (q_empty) begin
            fil_stop_q <= 1'b1;
            state_q    <= S_WFIL;
          end else begin
            ovf_q <= 1'b1;
          end
        end
        S_WFIL: if (fil_finish) begin
          finish_q <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign finish            = finish_q;
  assign busy              = (state_q != S_IDLE);
  assign sk_start          = sk_start_q;
  assign sk_pos            = sk_pos_q;
  assign sk_min_intv       = min_intv_q;
  assign sk_min_intv_valid = mv_q;
  assign rs_bypass         = (state_q != S_SEED);
  assign fil_start         = fil_start_q;
  assign fil_stop          = fil_stop_q;
  assign rsq_overflow      = ovf_q;

`ifdef MEM_SEED_SCHED_STATS_EN
  logic [15:0]     seeks_q;
  logic [7:0]      reseeds_q;
  logic [RSQ_AW:0] maxq_q;
  logic            reseed_ev;

  assign reseed_ev = (state_q == S_CHK) && pop_d;

  // Updates only while busy, so the values hold from finish to next start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seeks_q   <= '0;
      reseeds_q <= '0;
      maxq_q    <= '0;
    end else if (start_ok) begin
      seeks_q   <= (read_len != '0) ? 16'd1 : 16'd0;
      reseeds_q <= '0;
      maxq_q    <= '0;
    end else if (state_q != S_IDLE) begin
      if ((seek_more || reseed_ev) && (seeks_q != '1)) seeks_q <= seeks_q + 16'd1;
      if (reseed_ev && (reseeds_q != '1))              reseeds_q <= reseeds_q + 8'd1;
      if (q_count > maxq_q)                            maxq_q <= q_count;
    end
  end

  assign stat_seeks   = seeks_q;
  assign stat_reseeds = reseeds_q;
  assign stat_maxq    = maxq_q;
`endif

endmodule

// File: tb/tb_mem_seed_sched.sv
// Directed bench for mem_seed_sched (queue depth 4, reseed cap 2, settle 2).
module tb_mem_seed_sched;
  import BwaMemDefines::*;

  localparam int unsigned POS_W  = DEF_POS_W;
  localparam int unsigned KLS_W  = DEF_KLS_W;
  localparam int unsigned RSQ_AW = 2;
  localparam int unsigned DW     = 2*POS_W + KLS_W;

  logic             clk = 1'b0;
  logic             reset_n, start, sk_finish, rsc_tvalid, fil_finish;
  logic [POS_W-1:0] read_len, sk_nxt_pos;
  logic [DW-1:0]    rsc_tdata;
  logic             finish, busy, sk_start, sk_min_intv_valid, rs_bypass;
  logic             rsc_tready, fil_start, fil_stop, rsq_overflow;
  logic [POS_W-1:0] sk_pos;
  logic [KLS_W-1:0] sk_min_intv;
`ifdef MEM_SEED_SCHED_STATS_EN
  logic [15:0]      stat_seeks;
  logic [7:0]       stat_reseeds;
  logic [RSQ_AW:0]  stat_maxq;
`endif

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  mem_seed_sched #(
    .MAX_READ_LEN (250),
    .POS_W        (POS_W),
    .KLS_W        (KLS_W),
    .RSQ_AW       (RSQ_AW),
    .MAX_RESEED   (2),
    .SETTLE_CYC   (2)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .read_len          (read_len),
    .finish            (finish),
    .busy              (busy),
    .sk_start          (sk_start),
    .sk_pos            (sk_pos),
    .sk_min_intv       (sk_min_intv),
    .sk_min_intv_valid (sk_min_intv_valid),
    .sk_finish         (sk_finish),
    .sk_nxt_pos        (sk_nxt_pos),
    .rs_bypass         (rs_bypass),
    .rsc_tdata         (rsc_tdata),
    .rsc_tvalid        (rsc_tvalid),
    .rsc_tready        (rsc_tready),
    .fil_start         (fil_start),
    .fil_stop          (fil_stop),
    .fil_finish        (fil_finish),
    .rsq_overflow      (rsq_overflow)
`ifdef MEM_SEED_SCHED_STATS_EN
    ,
    .stat_seeks        (stat_seeks),
    .stat_reseeds      (stat_reseeds),
    .stat_maxq         (stat_maxq)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] cand(input int unsigned s, input int unsigned j, input int unsigned i);
    ReseedCand c;
    c.s = KLS_W'(s);
    c.j = POS_W'(j);
    c.i = POS_W'(i);
    return c;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; read_len = '0; sk_finish = 1'b0; sk_nxt_pos = '0;
    rsc_tdata = '0; rsc_tvalid = 1'b0; fil_finish = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_skstart", sk_start, 0);
    chk("rst_skpos", sk_pos, 0);
    chk("rst_minintv", sk_min_intv, 0);
    chk("rst_finish", finish, 0);
    chk("rst_ovf", rsq_overflow, 0);
    tick(); tick(); reset_n = 1'b1; tick();

    // Seeding pass over a 10-base read, nothing queued
    start = 1'b1; read_len = 10; tick(); start = 1'b0;
    chk("s1_skstart", sk_start, 1);
    chk("s1_pos1", sk_pos, 1);
    chk("s1_mv", sk_min_intv_valid, 1);
    chk("s1_filstart", fil_start, 1);
    chk("s1_busy", busy, 1);
    chk("s1_bypass_seed", rs_bypass, 0);
    sk_finish = 1'b1; sk_nxt_pos = 4; tick(); sk_finish = 1'b0;
    chk("s1_pos4", sk_pos, 4);
    chk("s1_skstart4", sk_start, 1);
    tick();
    chk("s1_skstart_gap", sk_start, 0);
    chk("s1_pos_stable", sk_pos, 4);
    sk_finish = 1'b1; sk_nxt_pos = 9; tick();
    chk("s1_pos9", sk_pos, 9);
    sk_nxt_pos = 13; tick(); sk_finish = 1'b0;
    chk("s1_end_nostart", sk_start, 0);
    chk("s1_end_pos", sk_pos, 9);
    chk("s1_bypass_settle", rs_bypass, 1);
    tick(); tick();
    chk("s1_settle_filstop", fil_stop, 0);
    tick();
    chk("s1_filstop", fil_stop, 1);
    fil_finish = 1'b1; tick(); fil_finish = 1'b0;
    chk("s1_finish", finish, 1);
    chk("s1_busy_low", busy, 0);
    chk("s1_filstop_pulse", fil_stop, 0);
    tick();
    chk("s1_finish_pulse", finish, 0);

    // Reseed positions, ignored start in SEED
    start = 1'b1; read_len = 10; tick(); start = 1'b0;
    chk("s2_pos1", sk_pos, 1);
    rsc_tvalid = 1'b1; rsc_tdata = cand(5, 8, 3);
    sk_finish = 1'b1; sk_nxt_pos = 4; start = 1'b1; tick(); start = 1'b0;
    chk("s2_ign_start_pos", sk_pos, 4);
    chk("s2_ign_start_fil", fil_start, 0);
    rsc_tdata = cand(2, 1, 1); sk_nxt_pos = 9; tick(); rsc_tvalid = 1'b0;
    chk("s2_pos9", sk_pos, 9);
    sk_nxt_pos = 13; tick(); sk_finish = 1'b0;
    tick(); tick(); tick();
    chk("s2_rs1_pos", sk_pos, 6);
    chk("s2_rs1_intv", sk_min_intv, 5);
    chk("s2_rs1_start", sk_start, 1);
    chk("s2_rs1_mv", sk_min_intv_valid, 1);
    chk("s2_rs1_bypass", rs_bypass, 1);
    sk_finish = 1'b1; sk_nxt_pos = 0; tick(); sk_finish = 1'b0;
    chk("s2_chk_nostart", sk_start, 0);
    tick();
    chk("s2_rs2_pos", sk_pos, 1);
    chk("s2_rs2_intv", sk_min_intv, 2);
    chk("s2_rs2_start", sk_start, 1);
    sk_finish = 1'b1; tick(); sk_finish = 1'b0;
    tick();
    chk("s2_filstop", fil_stop, 1);
    chk("s2_ovf", rsq_overflow, 0);
    fil_finish = 1'b1; tick(); fil_finish = 1'b0;
    chk("s2_finish", finish, 1);
`ifdef MEM_SEED_SCHED_STATS_EN
    chk("s2_stat_seeks", stat_seeks, 5);
    chk("s2_stat_reseeds", stat_reseeds, 2);
    chk("s2_stat_maxq", stat_maxq, 2);
    tick();
    chk("s2_stat_frozen", stat_seeks, 5);
`endif

    // Queue full, then reseed cap with flush
    start = 1'b1; read_len = 10; tick(); start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      rsc_tvalid = 1'b1;
      rsc_tdata  = cand(10 + k, 2*k + 2, 2*k);
      chk($sformatf("s3_ready%0d", k), rsc_tready, (k < 4) ? 1 : 0);
      tick();
    end
    rsc_tvalid = 1'b0; sk_finish = 1'b1; sk_nxt_pos = 200; tick(); sk_finish = 1'b0;
    tick(); tick();
    chk("s3_ready_full_pop", rsc_tready, 1);
    rsc_tvalid = 1'b1; rsc_tdata = cand(30, 20, 20); tick(); rsc_tvalid = 1'b0;
    chk("s3_rs1_pos", sk_pos, 1);
    chk("s3_rs1_intv", sk_min_intv, 10);
    chk("s3_ready_full", rsc_tready, 0);
    sk_finish = 1'b1; tick(); sk_finish = 1'b0;
    tick();
    chk("s3_rs2_pos", sk_pos, 3);
    chk("s3_rs2_intv", sk_min_intv, 11);
    sk_finish = 1'b1; tick(); sk_finish = 1'b0;
    tick();
    chk("s3_no_rs3", sk_start, 0);
    chk("s3_ovf_pre", rsq_overflow, 0);
    tick();
    chk("s3_ovf_set", rsq_overflow, 1);
    tick(); tick();
    chk("s3_flush_filstop", fil_stop, 0);
    tick();
    chk("s3_filstop", fil_stop, 1);
    chk("s3_ovf_sticky", rsq_overflow, 1);
    chk("s3_pos_kept", sk_pos, 3);
    fil_finish = 1'b1; tick(); fil_finish = 1'b0;
    chk("s3_finish", finish, 1);

    // Zero-length read skips seeding; early fil_finish ignored
    start = 1'b1; read_len = 0; tick(); start = 1'b0;
    chk("s4_filstart", fil_start, 1);
    chk("s4_no_skstart", sk_start, 0);
    fil_finish = 1'b1; tick(); fil_finish = 1'b0;
    chk("s4_busy", busy, 1);
    chk("s4_no_finish", finish, 0);
    tick();
    chk("s4_settle_filstop", fil_stop, 0);
    tick();
    chk("s4_filstop", fil_stop, 1);
    fil_finish = 1'b1; tick(); fil_finish = 1'b0;
    chk("s4_finish", finish, 1);

    // Asynchronous reset while reseeding, then a fresh 1-base read
    start = 1'b1; read_len = 1; tick(); start = 1'b0;
    rsc_tvalid = 1'b1; rsc_tdata = cand(7, 4, 2);
    sk_finish = 1'b1; sk_nxt_pos = 5; tick(); rsc_tvalid = 1'b0; sk_finish = 1'b0;
    tick(); tick(); tick();
    chk("s5_rs_pos", sk_pos, 3);
    chk("s5_rs_start", sk_start, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("s5_rst_pos", sk_pos, 0);
    chk("s5_rst_start", sk_start, 0);
    chk("s5_rst_mv", sk_min_intv_valid, 0);
    chk("s5_rst_intv", sk_min_intv, 0);
    chk("s5_rst_busy", busy, 0);
    tick(); tick();
    chk("s5_rst_finish", finish, 0);
    reset_n = 1'b1; tick();
    chk("s5_post_finish", finish, 0);
    start = 1'b1; read_len = 1; tick(); start = 1'b0;
    chk("s5_new_pos1", sk_pos, 1);
    chk("s5_new_start", sk_start, 1);
    sk_finish = 1'b1; sk_nxt_pos = 2; tick();
    chk("s5_new_pos2", sk_pos, 2);
    sk_nxt_pos = 3; tick(); sk_finish = 1'b0;
    tick(); tick(); tick();
    chk("s5_new_filstop", fil_stop, 1);
    fil_finish = 1'b1; tick(); fil_finish = 1'b0;
    chk("s5_new_finish", finish, 1);
    chk("s5_new_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
